math_peak_16: RTL and testbench

Frame peak finder for the magnitude stream produced by the 16-bit complex-magnitude stage. It consumes one unsigned 16-bit magnitude per valid cycle, tracks the per-frame maximum, its sample index and the frame energy sum, and registers a one-cycle report after each frame closes. It sits directly downstream of the magnitude block, on the same clock and clock enable, and feeds detection and threshold logic.

---
 rtl/math_peak_16.sv | 114 +++++++++++
 tb/tb_math_peak_16.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/math_peak_16.sv
// math_peak_16 -- frame peak finder for a 16-bit magnitude stream.
//
// Consumes one unsigned magnitude per valid cycle. For each frame it tracks
// the running maximum, the index of that maximum and the sample sum. One
// enabled cycle after the closing sample, it presents a report with a
// single-cycle strobe. A frame closes on din_last, or it is force-closed
// when it reaches 2^IDX_W samples.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides ena
//   ena        clock enable; every register holds while low
//   din        unsigned magnitude sample
//   din_valid  din is valid this cycle
//   din_last   final sample of the frame (qualified by din_valid)
//   peak_val   largest magnitude of the last reported frame
//   peak_idx   index of peak_val within that frame (first sample = 0)
//   sum        sum of all samples of that frame
//   len        number of samples in that frame
//   ovf        frame was force-closed at the length limit
//   dout_valid one-enabled-cycle report strobe
module math_peak_16 #(
   parameter int IDX_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [15:0]         din,
   input  logic                din_valid,
   input  logic                din_last,
   output logic [15:0]         peak_val,
   output logic [IDX_W-1:0]    peak_idx,
   output logic [16+IDX_W-1:0] sum,
   output logic [IDX_W:0]      len,
   output logic                ovf,
   output logic                dout_valid
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   state_t                state_reg;
   logic [IDX_W-1:0]      cnt_reg;
   logic [IDX_W-1:0]      cur_idx_reg;
   logic [15:0]           cur_max_reg;
   logic [16+IDX_W-1:0]   acc_reg;

   logic                  first_s;
   logic [IDX_W-1:0]      idx_s;
   logic [15:0]           max_next;
   logic [IDX_W-1:0]      idx_next;
   logic [16+IDX_W-1:0]   acc_next;
   logic [IDX_W:0]        len_next;
   logic                  at_limit;
   logic                  close_s;

   // Values that include the current sample. The first sample of a frame
   // loads directly, so nothing is compared against the previous frame.
   always_comb begin
      first_s  = (state_reg == IDLE);
      idx_s    = first_s ? '0 : cnt_reg;
      max_next = cur_max_reg;
      idx_next = cur_idx_reg;
      // A strict compare keeps the earliest index when values tie.
      if (first_s || (din > cur_max_reg)) begin
         max_next = din;
         idx_next = idx_s;
      end
      acc_next = first_s ? {{IDX_W{1'b0}}, din}
                         : acc_reg + {{IDX_W{1'b0}}, din};
      len_next = {1'b0, idx_s} + (IDX_W+1)'(1);
      at_limit = (idx_s == LAST_IDX);
      close_s  = din_last || at_limit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         cur_idx_reg <= '0;
         cur_max_reg <= '0;
         acc_reg     <= '0;
         peak_val    <= '0;
         peak_idx    <= '0;
         sum         <= '0;
         len         <= '0;
         ovf         <= 1'b0;
         dout_valid  <= 1'b0;
      end else if (ena) begin
         dout_valid <= 1'b0;
         if (din_valid) begin
            if (close_s) begin
               peak_val   <= max_next;
               peak_idx   <= idx_next;
               sum        <= acc_next;
               len        <= len_next;
               // din_last on the limit sample is a normal close.
               ovf        <= !din_last;
               dout_valid <= 1'b1;
               state_reg  <= IDLE;
               cnt_reg    <= '0;
            end else begin
               cur_max_reg <= max_next;
               cur_idx_reg <= idx_next;
               acc_reg     <= acc_next;
               cnt_reg     <= idx_s + IDX_W'(1);
               state_reg   <= ACTIVE;
            end
         end
      end
   end

endmodule

// File: tb/tb_math_peak_16.sv
// Directed testbench for math_peak_16 (IDX_W = 3). The stimulus pushes the
// expected report into a scoreboard queue just before it drives the closing
// sample. After each edge, the bench pops the report when a strobe is due.
// It then compares every output against the current expected report.
module tb_math_peak_16;

   localparam int IDX_W = 3;

   typedef struct {
      logic [15:0]         pv;
      logic [IDX_W-1:0]    pi;
      logic [16+IDX_W-1:0] s;
      logic [IDX_W:0]      l;
      logic                o;
   } rep_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                ena = 1'b0;
   logic [15:0]         din = '0;
   logic                din_valid = 1'b0;
   logic                din_last = 1'b0;
   logic [15:0]         peak_val;
   logic [IDX_W-1:0]    peak_idx;
   logic [16+IDX_W-1:0] sum;
   logic [IDX_W:0]      len;
   logic                ovf;
   logic                dout_valid;

   rep_t exp_q[$];
   rep_t last_rep;
   logic last_dv;
   int   errors = 0;
   int   checks = 0;

   math_peak_16 #(.IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .din(din), .din_valid(din_valid),
      .din_last(din_last), .peak_val(peak_val), .peak_idx(peak_idx),
      .sum(sum), .len(len), .ovf(ovf), .dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] pv, input int pi, input logic [31:0] s,
                       input int l, input logic o);
      rep_t r;
      r.pv = pv;
      r.pi = IDX_W'(pi);
      r.s  = (16+IDX_W)'(s);
      r.l  = (IDX_W+1)'(l);
      r.o  = o;
      exp_q.push_back(r);
   endtask

   // One clock cycle of stimulus followed by a full output check.
   task automatic step(input string tag, input logic en, input logic rs,
                       input logic v, input logic [15:0] d, input logic l);
      @(negedge clk);
      ena = en; rst = rs; din_valid = v; din = d; din_last = l;
      @(posedge clk);
      #1;
      if (rs) begin
         exp_q.delete();
         last_rep = '{16'h0, '0, '0, '0, 1'b0};
         last_dv  = 1'b0;
      end else if (en) begin
         if (exp_q.size() > 0) begin
            last_rep = exp_q.pop_front();
            last_dv  = 1'b1;
         end else begin
            last_dv = 1'b0;
         end
      end
      chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(last_dv));
      chk({tag, ".peak_val"},   32'(peak_val),   32'(last_rep.pv));
      chk({tag, ".peak_idx"},   32'(peak_idx),   32'(last_rep.pi));
      chk({tag, ".sum"},        32'(sum),        32'(last_rep.s));
      chk({tag, ".len"},        32'(len),        32'(last_rep.l));
      chk({tag, ".ovf"},        32'(ovf),        32'(last_rep.o));
      $display("step %-10s ena=%0b rst=%0b v=%0b din=%h last=%0b -> dv=%0b peak=%h idx=%0d sum=%h len=%0d ovf=%0b",
               tag, en, rs, v, d, l, dout_valid, peak_val, peak_idx, sum, len, ovf);
   endtask

   initial begin
      last_rep = '{16'h0, '0, '0, '0, 1'b0};
      last_dv  = 1'b0;

      // Reset state.
      step("reset0", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      step("reset1", 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
      step("idle", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

      // Basic frame 5,9,3,9,1 with a tie on 9: the earliest index wins.
      step("basic", 1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
      step("basic", 1'b1, 1'b0, 1'b1, 16'd9, 1'b0);
      step("basic", 1'b1, 1'b0, 1'b1, 16'd3, 1'b0);
      step("basic", 1'b1, 1'b0, 1'b1, 16'd9, 1'b0);
      push(16'd9, 1, 27, 5, 1'b0);
      step("basic", 1'b1, 1'b0, 1'b1, 16'd1, 1'b1);

      // Back-to-back frames {100} and {2,700}.
      push(16'd100, 0, 100, 1, 1'b0);
      step("b2b", 1'b1, 1'b0, 1'b1, 16'd100, 1'b1);
      step("b2b", 1'b1, 1'b0, 1'b1, 16'd2, 1'b0);
      push(16'd700, 1, 702, 2, 1'b0);
      step("b2b", 1'b1, 1'b0, 1'b1, 16'd700, 1'b1);
      // One-sample frames give strobes on consecutive cycles.
      push(16'd11, 0, 11, 1, 1'b0);
      step("single", 1'b1, 1'b0, 1'b1, 16'd11, 1'b1);
      push(16'd12, 0, 12, 1, 1'b0);
      step("single", 1'b1, 1'b0, 1'b1, 16'd12, 1'b1);
      step("idle", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);

      // Gaps, din_last without din_valid, and ena low mid-frame.
      step("gap", 1'b1, 1'b0, 1'b1, 16'd10, 1'b0);
      step("gap", 1'b1, 1'b0, 1'b0, 16'd500, 1'b1);
      step("gap", 1'b1, 1'b0, 1'b0, 16'd500, 1'b0);
      step("gap", 1'b1, 1'b0, 1'b0, 16'd500, 1'b0);
      step("gap_ena", 1'b0, 1'b0, 1'b1, 16'd99, 1'b1);
      step("gap", 1'b1, 1'b0, 1'b1, 16'd40, 1'b0);
      step("gap", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      step("gap_ena", 1'b0, 1'b0, 1'b1, 16'd77, 1'b0);
      push(16'd40, 1, 70, 3, 1'b0);
      step("gap", 1'b1, 1'b0, 1'b1, 16'd20, 1'b1);
      // With ena held low after the report, the strobe and outputs hold.
      for (int i = 0; i < 3; i++)
         step("hold", 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
      step("hold_end", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);

      // Length limit: 8 x 0xFFFF with no last forces ovf.
      for (int i = 0; i < 7; i++)
         step("ovf", 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      push(16'hFFFF, 0, 32'h7FFF8, 8, 1'b1);
      step("ovf", 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      // The next sample starts a new frame at index 0.
      step("after_ovf", 1'b1, 1'b0, 1'b1, 16'd7, 1'b0);
      push(16'd7, 0, 13, 2, 1'b0);
      step("after_ovf", 1'b1, 1'b0, 1'b1, 16'd6, 1'b1);

      // A full-length frame closed by din_last is not an overflow.
      for (int i = 0; i < 7; i++)
         step("maxlen", 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      push(16'hFFFF, 0, 32'h7FFF8, 8, 1'b0);
      step("maxlen", 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);

      // Reset mid-frame discards the frame. A valid sample during reset is dropped.
      step("rstmid", 1'b1, 1'b0, 1'b1, 16'd500, 1'b0);
      step("rstmid", 1'b1, 1'b0, 1'b1, 16'd600, 1'b0);
      step("rstmid", 1'b1, 1'b1, 1'b1, 16'd900, 1'b1);
      push(16'd3, 0, 3, 1, 1'b0);
      step("rstmid", 1'b1, 1'b0, 1'b1, 16'd3, 1'b1);
      step("idle", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
